// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: wraps MAC byte stream into an RGMII frame (preamble, SFD, payload, optional FCS, IFG)
// Ports: mac_clk/mac_rst_n (sync active-low); mac_startofpacket, mac_endofpacket, mac_valid,
//   mac_data, mac_error, mac_ready form the MAC-side stream; tx_data/tx_en/tx_er are registered
//   outputs to the RGMII DDR stage. Define RGMII_TX_FCS_EN to append the CRC-32 FCS.
module rgmii_tx_framer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  mac_clk,
    input  logic                  mac_rst_n,
    input  logic                  mac_startofpacket,
    input  logic                  mac_endofpacket,
    input  logic                  mac_valid,
    input  logic [DATA_WIDTH-1:0] mac_data,
    input  logic                  mac_error,
    output logic                  mac_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    output logic                  tx_er
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_IFG, S_DROP
`ifdef RGMII_TX_FCS_EN
        , S_FCS
`endif
    } state_t;
    state_t     state;
    logic [3:0] cnt;
`ifdef RGMII_TX_FCS_EN
    logic [31:0] crc;
    logic [31:0] fcs;
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction
    always_comb fcs = ~crc;
`endif
    // a start-of-packet beat in idle is held back so it becomes the first payload byte
    always_comb mac_ready = mac_rst_n && (state == S_DATA || state == S_DROP ||
                                          (state == S_IDLE && !mac_startofpacket));
    always_ff @(posedge mac_clk) begin
        if (!mac_rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            tx_en   <= 1'b0;
            tx_er   <= 1'b0;
            tx_data <= 8'h00;
`ifdef RGMII_TX_FCS_EN
            crc     <= 32'd0;
`endif
        end else begin
            tx_en   <= 1'b0;
            tx_er   <= 1'b0;
            tx_data <= 8'h00;
            case (state)
                S_IDLE: if (mac_valid && mac_startofpacket) begin
                    state   <= S_PREAMBLE;
                    cnt     <= 4'd0;
                    tx_en   <= 1'b1;
                    tx_data <= 8'h55;
`ifdef RGMII_TX_FCS_EN
                    crc     <= 32'hFFFFFFFF;
`endif
                end
                S_PREAMBLE: begin
                    tx_en   <= 1'b1;
                    cnt     <= cnt + 4'd1;
                    tx_data <= (cnt == 4'd6) ? 8'hD5 : 8'h55;
                    if (cnt == 4'd6) state <= S_DATA;
                end
                S_DATA: begin
                    tx_en <= 1'b1;
                    if (mac_valid) begin
                        tx_data <= mac_data[7:0];
                        tx_er   <= mac_error;
`ifdef RGMII_TX_FCS_EN
                        crc     <= crc_byte(crc, mac_data[7:0]);
                        if (mac_endofpacket) state <= S_FCS;
`else
                        if (mac_endofpacket) state <= S_IFG;
`endif
                        cnt <= 4'd0;
                    end else begin
                        tx_er <= 1'b1;
                        state <= S_DROP;
                    end
                end
`ifdef RGMII_TX_FCS_EN
                S_FCS: begin
                    tx_en   <= 1'b1;
                    tx_data <= fcs[{cnt[1:0], 3'b000} +: 8];
                    cnt     <= (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
                    if (cnt == 4'd3) state <= S_IFG;
                end
`endif
                // first IFG cycle carries the final frame byte, leaving 12 idle output cycles before the next preamble
                S_IFG: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd11) state <= S_IDLE;
                end
                S_DROP: if (mac_valid && mac_endofpacket) begin
                    state <= S_IFG;
                    cnt   <= 4'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
